// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: bit-period tick, evenly spread OVS-times oversampling
// tick and half-bit tick, with a runtime-loadable divisor and synchronous phase realign.
module uart_baud_gen #(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned OVS         = 16,
  parameter int unsigned DEFAULT_DIV = 10417
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_load,
  input  logic             i_restart,
  output logic             o_tx_tick,
  output logic             o_rx_tick,
  output logic             o_mid_tick,
  output logic             o_clamped
);

  localparam int unsigned ACC_W = CNT_W + 1;
  localparam logic [ACC_W-1:0] OVS_EXT = ACC_W'(OVS);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tx_q, tx_d;
  logic             rx_q, rx_d;
  logic             mid_q, mid_d;
  logic             clamped_q, clamped_d;

  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] half_m1;
  logic [ACC_W-1:0] div_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             load_short;

  assign div_m1     = div_q - CNT_W'(1);
  assign half_m1    = (div_q >> 1) - CNT_W'(1);
  assign div_ext    = {1'b0, div_q};
  assign acc_sum    = acc_q + OVS_EXT;
  assign load_short = ({1'b0, i_div} < OVS_EXT);

  // Next state: load > restart > count > hold; ticks default low.
  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    clamped_d = clamped_q;
    tx_d      = 1'b0;
    rx_d      = 1'b0;
    mid_d     = 1'b0;
    if (i_div_load) begin
      clamped_d = load_short;
      div_d     = load_short ? OVS_EXT[CNT_W-1:0] : i_div;
      cnt_d     = '0;
      acc_d     = '0;
    end else if (i_restart) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == div_m1) ? '0 : cnt_q + CNT_W'(1);
      tx_d  = (cnt_q == div_m1);
      mid_d = (cnt_q == half_m1);
      // Bresenham-style spreading: OVS rx ticks per div clocks, wrapping with cnt.
      if (acc_sum >= div_ext) begin
        acc_d = acc_sum - div_ext;
        rx_d  = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      div_q     <= DIV_RST;
      cnt_q     <= '0;
      acc_q     <= '0;
      tx_q      <= 1'b0;
      rx_q      <= 1'b0;
      mid_q     <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      mid_q     <= mid_d;
      clamped_q <= clamped_d;
    end
  end

  assign o_tx_tick  = tx_q;
  assign o_rx_tick  = rx_q;
  assign o_mid_tick = mid_q;
  assign o_clamped  = clamped_q;

endmodule
